// File: rtl/tribus_responder.sv
// tribus_responder: register-file target on a shared single-clock tristate bus.
// Writes land in a 2**AW-entry register file. Reads are answered after a
// programmable wait by driving the bus for one cycle. A mandatory turnaround
// cycle follows every read before the next request is accepted.
module tribus_responder #(
  parameter int DW     = 8,
  parameter int AW     = 2,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  inout  tri   [DW-1:0] data,
  output logic          ack,
  output logic          oe
);

  localparam int         DEPTH = 2 ** AW;
  localparam logic [2:0] LAT   = 3'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE,
    WACK,
    RWAIT,
    DRIVE,
    TURN
  } state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [AW-1:0] raddr;
  logic [DW-1:0] regs [DEPTH];

  // Bus driver. oe is a flop with asynchronous clear, so reset releases the
  // bus at once without waiting for a clock edge.
  assign data = oe ? regs[raddr] : {DW{1'bz}};

  // Transaction FSM together with the register file, raddr and the
  // registered ack/oe strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      raddr <= '0;
      ack   <= 1'b0;
      oe    <= 1'b0;
      // NOTE: the register file is only 2**AW words and must read back as
      // zero after reset, so it is cleared here rather than left uninitialised
      // like a RAM macro would be.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // NOTE: every assignment in this block is non-blocking so all state
      // updates see the pre-edge values; the defaults below make ack and oe
      // single-cycle strobes unless a branch re-asserts them.
      ack <= 1'b0;
      oe  <= 1'b0;
      case (state)
        IDLE: begin
          if (cs) begin
            if (we) begin
              regs[addr] <= data;
              ack        <= 1'b1;
              state      <= WACK;
            end else begin
              raddr <= addr;
              if (LAT == 3'd0) begin
                oe    <= 1'b1;
                ack   <= 1'b1;
                state <= DRIVE;
              end else begin
                cnt   <= LAT;
                state <= RWAIT;
              end
            end
          end
        end
        WACK: begin
          state <= IDLE;
        end
        RWAIT: begin
          if (!cs) begin
            // Initiator gave up: drop the read without ack or drive.
            state <= IDLE;
          end else if (cnt == 3'd1) begin
            oe    <= 1'b1;
            ack   <= 1'b1;
            state <= DRIVE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DRIVE: begin
          state <= TURN;
        end
        TURN: begin
          // Turnaround: cs is deliberately ignored for this one cycle.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The bus may only be driven while answering a read.
  a_oe_only_in_drive: assert property (
    @(posedge clk) disable iff (reset) oe |-> (state == DRIVE)
  );

endmodule

// File: tb/tb_tribus_responder.sv
// tb_tribus_responder: three responders (RD_LAT = 1, 3, 0) on separate buses.
// Stimulus tasks push the expected response into a per-lane queue; a monitor
// on the falling edge pops and compares whenever a responder raises ack.
module tb_tribus_responder;

  localparam int LAT [3] = '{1, 3, 0};

  typedef struct {
    bit         is_read;
    logic [7:0] data;
    int         at_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cs     = '0;
  logic [2:0] we     = '0;
  logic [2:0] drv_en = '0;
  logic [1:0] addr    [3];
  logic [7:0] drv_val [3];
  wire  [7:0] bus0, bus1, bus2;
  wire  [2:0] ack, oe;

  int n_vec      = 0;
  int n_bad      = 0;
  int cyc        = 0;
  int x_seen     = 0;
  int contention = 0;

  logic [7:0] mdl [3][4];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Initiator-side tristate drivers, one per bus.
  assign bus0 = drv_en[0] ? drv_val[0] : 'z;
  assign bus1 = drv_en[1] ? drv_val[1] : 'z;
  assign bus2 = drv_en[2] ? drv_val[2] : 'z;

  tribus_responder #(.DW(8), .AW(2), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .cs(cs[0]), .we(we[0]), .addr(addr[0]),
    .data(bus0), .ack(ack[0]), .oe(oe[0])
  );
  tribus_responder #(.DW(8), .AW(2), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .cs(cs[1]), .we(we[1]), .addr(addr[1]),
    .data(bus1), .ack(ack[1]), .oe(oe[1])
  );
  tribus_responder #(.DW(8), .AW(2), .RD_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .cs(cs[2]), .we(we[2]), .addr(addr[2]),
    .data(bus2), .ack(ack[2]), .oe(oe[2])
  );

  function automatic logic [7:0] bus_of(int l);
    case (l)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  function automatic int qsize(int l);
    case (l)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(int l, exp_t e);
    case (l)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(int l, output exp_t e);
    case (l)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after the edge that makes cyc == t.
  task automatic wait_cyc(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write: capture happens dly edges from now; ack is due in the next cycle.
  // Returns inside the WACK cycle with cs still high.
  task automatic wr(int l, logic [1:0] a, logic [7:0] d, int dly);
    exp_t e;
    int   k;
    k = cyc + dly;
    // NOTE: bench inputs are driven with blocking assignments 1 time unit
    // after a rising edge, so the DUT never sees them change at its edge.
    cs[l] = 1'b1; we[l] = 1'b1; addr[l] = a;
    drv_val[l] = d; drv_en[l] = 1'b1;
    e.is_read = 1'b0; e.data = d; e.at_cyc = k;
    push(l, e);
    mdl[l][a] = d;
    wait_cyc(k);
  endtask

  // Read: capture happens dly edges from now; drive+ack are due LAT cycles
  // after the capture cycle. Returns inside the TURN cycle with cs low.
  task automatic rd(int l, logic [1:0] a, logic [7:0] exp, int dly);
    exp_t e;
    int   k;
    k = cyc + dly;
    cs[l] = 1'b1; we[l] = 1'b0; addr[l] = a; drv_en[l] = 1'b0;
    e.is_read = 1'b1; e.data = exp; e.at_cyc = k + LAT[l];
    push(l, e);
    wait_cyc(k);
    addr[l] = ~a;
    wait_cyc(k + LAT[l]);
    cs[l] = 1'b0;
    wait_cyc(k + LAT[l] + 1);
  endtask

  task automatic idle(int l, int n);
    cs[l] = 1'b0; drv_en[l] = 1'b0;
    wait_cyc(cyc + n);
  endtask

  // Scoreboard monitor: every ack must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int l = 0; l < 3; l++) begin
        if (oe[l] && drv_en[l]) contention++;
        if (oe[l] && $isunknown(bus_of(l))) x_seen++;
        if (ack[l]) begin
          check($sformatf("ack_expected_l%0d", l), 32'(qsize(l) != 0), 32'd1);
          if (qsize(l) != 0) begin
            pop(l, mon_e);
            check($sformatf("ack_cycle_l%0d", l), cyc, mon_e.at_cyc);
            check($sformatf("ack_oe_l%0d", l), 32'(oe[l]), 32'(mon_e.is_read));
            if (mon_e.is_read)
              check($sformatf("read_data_l%0d", l), 32'(bus_of(l)), 32'(mon_e.data));
          end
        end
      end
    end
  end

  initial begin
    int dly;
    logic [1:0] ra;
    for (int l = 0; l < 3; l++) begin
      addr[l] = '0; drv_val[l] = '0;
      for (int a = 0; a < 4; a++) mdl[l][a] = '0;
    end
    reset = 1'b1;
    #7;
    check("reset_oe", 32'(oe), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cyc(cyc + 1);

    // Single write then read on the RD_LAT=1 responder.
    wr(0, 2'd2, 8'hA5, 1);
    idle(0, 1);
    rd(0, 2'd2, 8'hA5, 1);
    idle(0, 1);

    // Reset in the middle of DRIVE must release the bus with no clock edge.
    cs[0] = 1'b1; we[0] = 1'b0; addr[0] = 2'd2;
    wait_cyc(cyc + 2);
    check("pre_reset_oe", 32'(oe[0]), 32'd1);
    check("pre_reset_data", 32'(bus0), 32'hA5);
    reset = 1'b1;
    #1;
    check("reset_async_oe", 32'(oe[0]), 32'd0);
    check("reset_async_ack", 32'(ack[0]), 32'd0);
    cs[0] = 1'b0;
    wait_cyc(cyc + 2);
    reset = 1'b0;
    for (int l = 0; l < 3; l++)
      for (int a = 0; a < 4; a++) mdl[l][a] = '0;
    for (int a = 0; a < 4; a++) rd(0, 2'(a), 8'h00, (a == 0) ? 1 : 2);
    idle(0, 1);

    // Back-to-back writes with cs held high, then readback.
    wr(0, 2'd0, 8'h11, 1);
    wr(0, 2'd1, 8'h22, 2);
    wr(0, 2'd2, 8'h33, 2);
    wr(0, 2'd3, 8'h44, 2);
    idle(0, 1);
    rd(0, 2'd0, 8'h11, 1);
    rd(0, 2'd1, 8'h22, 2);
    rd(0, 2'd2, 8'h33, 2);
    rd(0, 2'd3, 8'h44, 2);
    idle(0, 1);

    // RD_LAT=3: read abort after one wait cycle, then a normal write.
    wr(1, 2'd1, 8'h3C, 1);
    idle(1, 1);
    cs[1] = 1'b1; we[1] = 1'b0; addr[1] = 2'd1;
    wait_cyc(cyc + 1);
    cs[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(cyc + 1);
      check("abort_oe", 32'(oe[1]), 32'd0);
      check("abort_ack", 32'(ack[1]), 32'd0);
    end
    wr(1, 2'd2, 8'h96, 1);
    idle(1, 1);
    rd(1, 2'd1, 8'h3C, 1);
    rd(1, 2'd2, 8'h96, 2);
    idle(1, 1);

    // RD_LAT=0: drive in the cycle right after capture; a request held
    // during TURN is only accepted on the following edge.
    wr(2, 2'd3, 8'h5C, 1);
    idle(2, 1);
    rd(2, 2'd3, 8'h5C, 1);
    wr(2, 2'd0, 8'hE7, 2);
    idle(2, 1);
    rd(2, 2'd0, 8'hE7, 1);
    rd(2, 2'd3, 8'h5C, 2);
    idle(2, 1);

    // Random mixed traffic on the RD_LAT=1 responder.
    dly = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(0, $urandom_range(1, 2));
        dly = 1;
      end
      ra = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) wr(0, ra, 8'($urandom), dly);
      else                           rd(0, ra, mdl[0][ra], dly);
      dly = 2;
    end
    idle(0, 1);

    wait_cyc(cyc + 10);
    for (int l = 0; l < 3; l++)
      check($sformatf("acks_outstanding_l%0d", l), qsize(l), 0);
    check("bus_contention", contention, 0);
    check("x_during_drive", x_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
